// File: rtl/lcd_8080_pkg.sv
// Shared constants and types for the 8080-bus LCD receiver.
package lcd_8080_pkg;

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        IDLE,
        CASET,
        PASET,
        RAMWR,
        PARAM
    } state_t;

    // Position within the 4-byte start/end parameter sequence of CASET/PASET.
    typedef logic [1:0] byte_idx_t;
    localparam byte_idx_t LAST_BYTE = 2'd3;

endpackage

// File: rtl/lcd_8080_sync.sv
// Two-flop synchronisers for the asynchronous 8080 bus plus write_n rising-edge
// detection; strobe, d_c_n and data leave together from one registered stage.
module lcd_8080_sync #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_write_n,
    input  logic              i_d_c_n,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_strobe,
    output logic              o_d_c_n,
    output logic [DATA_W-1:0] o_data
);

    logic              r_wr_meta, r_wr_sync, r_wr_prev;
    logic              r_dc_meta, r_dc_sync;
    logic [DATA_W-1:0] r_data_meta, r_data_sync;
    logic              r_strobe, r_dc;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the write_n chain resets to the idle-high bus level so that
            // leaving reset with write_n high never fakes a rising edge.
            r_wr_meta   <= 1'b1;
            r_wr_sync   <= 1'b1;
            r_wr_prev   <= 1'b1;
            r_dc_meta   <= 1'b0;
            r_dc_sync   <= 1'b0;
            r_data_meta <= '0;
            r_data_sync <= '0;
            r_strobe    <= 1'b0;
            r_dc        <= 1'b0;
            r_data      <= '0;
        end else begin
            r_wr_meta   <= i_write_n;
            r_wr_sync   <= r_wr_meta;
            r_wr_prev   <= r_wr_sync;
            r_dc_meta   <= i_d_c_n;
            r_dc_sync   <= r_dc_meta;
            r_data_meta <= i_data;
            r_data_sync <= r_data_meta;
            r_strobe    <= r_wr_sync & ~r_wr_prev;
            r_dc        <= r_dc_sync;
            r_data      <= r_data_sync;
        end
    end

    assign o_strobe = r_strobe;
    assign o_d_c_n  = r_dc;
    assign o_data   = r_data;

endmodule

// File: rtl/lcd_8080_rx.sv
// 8080 write-bus receiver: decodes commands/parameters, tracks the ILI9341
// column/page window and emits pixels with coordinates. LCD_RX_STATS_EN adds counters.
module lcd_8080_rx
    import lcd_8080_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int COORD_W = 9,
    parameter int X_MAX   = 239,
    parameter int Y_MAX   = 319
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lcd_d_c_n,
    input  logic               lcd_write_n,
    input  logic [DATA_W-1:0]  lcd_databus,
    output logic               cmd_valid,
    output logic [7:0]         cmd_code,
    output logic               param_valid,
    output logic [7:0]         param_data,
    output logic               pixel_valid,
    output logic [DATA_W-1:0]  pixel_data,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
`ifdef LCD_RX_STATS_EN
    output logic [31:0]        pixel_count,
    output logic [15:0]        frame_count,
`endif
    output logic               frame_start
);

    localparam logic [COORD_W-1:0] XM = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YM = COORD_W'(Y_MAX);

    logic              w_strobe, w_dc;
    logic [DATA_W-1:0] w_data;
    logic [7:0]        w_byte;

    lcd_8080_sync #(.DATA_W(DATA_W)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .i_write_n(lcd_write_n),
        .i_d_c_n  (lcd_d_c_n),
        .i_data   (lcd_databus),
        .o_strobe (w_strobe),
        .o_d_c_n  (w_dc),
        .o_data   (w_data)
    );

    assign w_byte = w_data[7:0];

    state_t             r_state;
    byte_idx_t          r_idx;
    logic [7:0]         r_start_hi, r_start_lo, r_end_hi;
    logic [COORD_W-1:0] r_sc, r_ec, r_sp, r_ep, r_x, r_y;
    logic               r_first;

    logic               r_cmd_valid, r_param_valid, r_pixel_valid, r_frame_start;
    logic [7:0]         r_cmd_code, r_param_data;
    logic [DATA_W-1:0]  r_pixel_data;
    logic [COORD_W-1:0] r_pixel_x, r_pixel_y;

    // Window bounds are compared after truncation to the coordinate width.
    logic [15:0]        w_start_full, w_end_full;
    logic [COORD_W-1:0] w_start, w_end;
    logic               w_order_ok;

    assign w_start_full = {r_start_hi, r_start_lo};
    assign w_end_full   = {r_end_hi, w_byte};
    assign w_start      = w_start_full[COORD_W-1:0];
    assign w_end        = w_end_full[COORD_W-1:0];
    assign w_order_ok   = (w_start <= w_end);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_start_hi    <= '0;
            r_start_lo    <= '0;
            r_end_hi      <= '0;
            r_sc          <= '0;
            r_ec          <= XM;
            r_sp          <= '0;
            r_ep          <= YM;
            r_x           <= '0;
            r_y           <= '0;
            r_first       <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd_code    <= '0;
            r_param_valid <= 1'b0;
            r_param_data  <= '0;
            r_pixel_valid <= 1'b0;
            r_pixel_data  <= '0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_cmd_valid   <= 1'b0;
            r_param_valid <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_frame_start <= 1'b0;
            if (w_strobe && !w_dc) begin
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= w_byte;
                r_idx       <= '0;
                case (w_byte)
                    CMD_CASET: r_state <= CASET;
                    CMD_PASET: r_state <= PASET;
                    CMD_RAMWR: begin
                        r_state <= RAMWR;
                        r_x     <= r_sc;
                        r_y     <= r_sp;
                        r_first <= 1'b1;
                    end
                    default:   r_state <= PARAM;
                endcase
            end else if (w_strobe) begin
                case (r_state)
                    CASET, PASET: begin
                        r_param_valid <= 1'b1;
                        r_param_data  <= w_byte;
                        r_idx         <= r_idx + 1'b1;
                        case (r_idx)
                            2'd0:    r_start_hi <= w_byte;
                            2'd1:    r_start_lo <= w_byte;
                            2'd2:    r_end_hi   <= w_byte;
                            default: ;
                        endcase
                        if (r_idx == LAST_BYTE) begin
                            r_state <= PARAM;
                            if (r_state == CASET && w_order_ok && w_end <= XM) begin
                                r_sc <= w_start;
                                r_ec <= w_end;
                            end else if (r_state == PASET && w_order_ok && w_end <= YM) begin
                                r_sp <= w_start;
                                r_ep <= w_end;
                            end
                        end
                    end
                    PARAM: begin
                        r_param_valid <= 1'b1;
                        r_param_data  <= w_byte;
                    end
                    RAMWR: begin
                        r_pixel_valid <= 1'b1;
                        r_pixel_data  <= w_data;
                        r_pixel_x     <= r_x;
                        r_pixel_y     <= r_y;
                        r_frame_start <= r_first;
                        r_first       <= 1'b0;
                        if (r_x == r_ec) begin
                            r_x <= r_sc;
                            r_y <= (r_y == r_ep) ? r_sp : r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_code    = r_cmd_code;
    assign param_valid = r_param_valid;
    assign param_data  = r_param_data;
    assign pixel_valid = r_pixel_valid;
    assign pixel_data  = r_pixel_data;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign frame_start = r_frame_start;

`ifdef LCD_RX_STATS_EN
    logic [31:0] r_pixel_count;
    logic [15:0] r_frame_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pixel_count <= '0;
            r_frame_count <= '0;
        end else begin
            if (r_pixel_valid) r_pixel_count <= r_pixel_count + 1'b1;
            if (r_frame_start) r_frame_count <= r_frame_count + 1'b1;
        end
    end

    assign pixel_count = r_pixel_count;
    assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_lcd_8080_rx.sv
// Directed, table-driven bench for lcd_8080_rx: each bus write is checked for
// event type, payload, coordinates, frame_start and the 4-clock latency.
module tb_lcd_8080_rx;

    typedef enum logic [2:0] {K_NONE, K_CMD, K_PARAM, K_PIX, K_MULTI} kind_t;

    typedef struct {
        bit          rst_before;
        bit          dc;
        logic [15:0] data;
        kind_t       kind;
        logic [15:0] val;
        logic [8:0]  x;
        logic [8:0]  y;
        bit          fs;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lcd_d_c_n = 1'b1;
    logic        lcd_write_n = 1'b1;
    logic [15:0] lcd_databus = '0;
    logic        cmd_valid, param_valid, pixel_valid, frame_start;
    logic [7:0]  cmd_code, param_data;
    logic [15:0] pixel_data;
    logic [8:0]  pixel_x, pixel_y;
`ifdef LCD_RX_STATS_EN
    logic [31:0] pixel_count;
    logic [15:0] frame_count;
`endif

    lcd_8080_rx dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_d_c_n  (lcd_d_c_n),
        .lcd_write_n(lcd_write_n),
        .lcd_databus(lcd_databus),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .param_valid(param_valid),
        .param_data (param_data),
        .pixel_valid(pixel_valid),
        .pixel_data (pixel_data),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
`ifdef LCD_RX_STATS_EN
        .pixel_count(pixel_count),
        .frame_count(frame_count),
`endif
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
        else n_pass++;
    endtask

    function automatic logic [63:0] all_outputs();
        return {10'd0, cmd_valid, cmd_code, param_valid, param_data,
                pixel_valid, pixel_data, pixel_x, pixel_y, frame_start};
    endfunction

    function automatic void add(bit rb, bit dc, logic [15:0] d, kind_t k,
                                logic [15:0] v, logic [8:0] x, logic [8:0] y, bit fs);
        vec_t e;
        e.rst_before = rb; e.dc = dc; e.data = d; e.kind = k;
        e.val = v; e.x = x; e.y = y; e.fs = fs;
        vecs.push_back(e);
    endfunction

    function automatic void cmd(logic [7:0] c, bit rb = 1'b0);
        add(rb, 1'b0, {8'h00, c}, K_CMD, {8'h00, c}, 9'd0, 9'd0, 1'b0);
    endfunction

    function automatic void prm(logic [7:0] b);
        add(1'b0, 1'b1, {8'h00, b}, K_PARAM, {8'h00, b}, 9'd0, 9'd0, 1'b0);
    endfunction

    function automatic void pix(logic [15:0] d, int x, int y, bit fs);
        add(1'b0, 1'b1, d, K_PIX, d, 9'(x), 9'(y), fs);
    endfunction

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One bus write: 4 clocks low, then observe for 4 clocks after the rise.
    task automatic bus_write(input bit dc, input logic [15:0] d,
                             output kind_t k, output logic [15:0] v,
                             output logic [8:0] x, output logic [8:0] y,
                             output bit fs, output bit early);
        int nv;
        @(negedge clk);
        lcd_d_c_n = dc; lcd_databus = d; lcd_write_n = 1'b0;
        repeat (4) @(negedge clk);
        lcd_write_n = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cmd_valid || param_valid || pixel_valid || frame_start) early = 1'b1;
        end
        @(negedge clk);
        nv = int'(cmd_valid) + int'(param_valid) + int'(pixel_valid);
        v = '0; x = '0; y = '0;
        if (nv > 1)           k = K_MULTI;
        else if (cmd_valid)   begin k = K_CMD;   v = {8'h00, cmd_code}; end
        else if (param_valid) begin k = K_PARAM; v = {8'h00, param_data}; end
        else if (pixel_valid) begin k = K_PIX;   v = pixel_data; x = pixel_x; y = pixel_y; end
        else                  k = K_NONE;
        fs = frame_start;
    endtask

    initial begin
        kind_t       k;
        logic [15:0] v;
        logic [8:0]  x, y;
        bit          fs, early;

        // RAMWR with default window
        cmd(8'h2C, 1'b1);
        pix(16'hF800, 0, 0, 1'b1); pix(16'h07E0, 1, 0, 1'b0); pix(16'h001F, 2, 0, 1'b0);
        // 3x2 window: row advance and wrap back to the top-left corner
        cmd(8'h2A); prm(8'h00); prm(8'h0A); prm(8'h00); prm(8'h0C);
        cmd(8'h2B); prm(8'h00); prm(8'h05); prm(8'h00); prm(8'h06);
        cmd(8'h2C);
        pix(16'h1000, 10, 5, 1'b1); pix(16'h1001, 11, 5, 1'b0); pix(16'h1002, 12, 5, 1'b0);
        pix(16'h1003, 10, 6, 1'b0); pix(16'h1004, 11, 6, 1'b0); pix(16'h1005, 12, 6, 1'b0);
        pix(16'h1006, 10, 5, 1'b0);
        // start > end rejected
        cmd(8'h2A, 1'b1); prm(8'h00); prm(8'h14); prm(8'h00); prm(8'h0A);
        cmd(8'h2C); pix(16'hABCD, 0, 0, 1'b1);
        // end > X_MAX rejected
        cmd(8'h2A); prm(8'h00); prm(8'h05); prm(8'h00); prm(8'hF0);
        cmd(8'h2C); pix(16'h1234, 0, 0, 1'b1);
        // partial CASET aborted by RAMWR
        cmd(8'h2A); prm(8'h00); prm(8'h05);
        cmd(8'h2C); pix(16'h5555, 0, 0, 1'b1);
        // generic command with parameters
        cmd(8'h36); prm(8'h48); prm(8'h99);
        // end == X_MAX accepted, column wrap at the right edge
        cmd(8'h2A); prm(8'h00); prm(8'hEE); prm(8'h00); prm(8'hEF);
        cmd(8'h2C);
        pix(16'h0EE0, 238, 0, 1'b1); pix(16'h0EF0, 239, 0, 1'b0); pix(16'h0EE1, 238, 1, 1'b0);
        // data in IDLE after reset is ignored
        add(1'b1, 1'b1, 16'h7777, K_NONE, 16'h0000, 9'd0, 9'd0, 1'b0);

        do_reset();
        check("reset_outputs", all_outputs(), 64'd0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            bus_write(vecs[i].dc, vecs[i].data, k, v, x, y, fs, early);
            check($sformatf("vec%0d dc=%0d data=%h", i, vecs[i].dc, vecs[i].data),
                  {24'd0, early, k, v, x, y, fs},
                  {24'd0, 1'b0, vecs[i].kind, vecs[i].val, vecs[i].x, vecs[i].y, vecs[i].fs});
        end

        // Reset asserted in the middle of a RAMWR burst
        do_reset();
        bus_write(1'b0, 16'h002C, k, v, x, y, fs, early);
        bus_write(1'b1, 16'hAAAA, k, v, x, y, fs, early);
        bus_write(1'b1, 16'hBBBB, k, v, x, y, fs, early);
        check("burst_pixel2", {early, k, v, x, y, fs}, {1'b0, K_PIX, 16'hBBBB, 9'd1, 9'd0, 1'b0});
        @(negedge clk);
`ifdef LCD_RX_STATS_EN
        check("stats_before_reset", {pixel_count, frame_count}, {32'd2, 16'd1});
`endif
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", all_outputs(), 64'd0);
`ifdef LCD_RX_STATS_EN
        check("stats_after_reset", {pixel_count, frame_count}, 48'd0);
`endif
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        bus_write(1'b1, 16'hCCCC, k, v, x, y, fs, early);
        check("idle_after_reset", {early, k, fs}, {1'b0, K_NONE, 1'b0});
        bus_write(1'b0, 16'h002C, k, v, x, y, fs, early);
        bus_write(1'b1, 16'hDDDD, k, v, x, y, fs, early);
        check("pixel_after_reset", {early, k, v, x, y, fs}, {1'b0, K_PIX, 16'hDDDD, 9'd0, 9'd0, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
